// File: rtl/ren_tri_setup_v2.sv
// Triangle setup stage: edge equations, signed area, culling, clamped tile bbox and attribute deltas.
// One shared multiplier pair produces the three edge c terms over three consecutive cycles.
module ren_tri_setup_v2 #(
    parameter int COORD_W   = 16,
    parameter int ATTR_W    = 16,
    parameter int NUM_ATTR  = 4,
    parameter int TILE_LOG2 = 3,
    parameter int SCREEN_W  = 640,
    parameter int SCREEN_H  = 480
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic                             i_valid,
    output logic                             o_ready,
    input  logic [3*COORD_W-1:0]             i_vtx_x,
    input  logic [3*COORD_W-1:0]             i_vtx_y,
    input  logic [3*NUM_ATTR*ATTR_W-1:0]     i_attr,
    input  logic [1:0]                       i_cull_mode,
    output logic                             o_valid,
    input  logic                             i_ready,
    output logic [3*(COORD_W+1)-1:0]         o_e_a,
    output logic [3*(COORD_W+1)-1:0]         o_e_b,
    output logic [3*(2*COORD_W+1)-1:0]       o_e_c,
    output logic [2*COORD_W+2:0]             o_area2,
    output logic [15:0]                      o_min_tile_x,
    output logic [15:0]                      o_min_tile_y,
    output logic [15:0]                      o_steps_x,
    output logic [15:0]                      o_steps_y,
    output logic [NUM_ATTR*ATTR_W-1:0]       o_attr_base,
    output logic [NUM_ATTR*(ATTR_W+1)-1:0]   o_attr_d0,
    output logic [NUM_ATTR*(ATTR_W+1)-1:0]   o_attr_d1,
    output logic [15:0]                      o_cull_cnt,
    output logic                             o_idle
);
    // Input handshake: accept when i_valid && o_ready; output transfer when o_valid && i_ready.
    localparam int AW = COORD_W + 1;
    localparam int PW = 2 * COORD_W;
    localparam int CW = 2 * COORD_W + 1;
    localparam int RW = 2 * COORD_W + 3;
    localparam int DW = ATTR_W + 1;
    localparam int VW = NUM_ATTR * ATTR_W;
    localparam logic signed [31:0] XMAX = 32'(SCREEN_W - 1);
    localparam logic signed [31:0] YMAX = 32'(SCREEN_H - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_EDGE, S_CMUL0, S_CMUL1, S_CMUL2, S_AREA, S_ATTR, S_OUT
    } state_t;

    state_t state_q, state_d;
    logic [2:0] attr_idx_q;

    logic signed [COORD_W-1:0] x_q [3];
    logic signed [COORD_W-1:0] y_q [3];
    logic [3*VW-1:0]           attr_q;
    logic [1:0]                mode_q;
    logic signed [AW-1:0]      a_q [3];
    logic signed [AW-1:0]      b_q [3];
    logic signed [CW-1:0]      c_q [3];

    logic [3*AW-1:0]       e_a_q, e_b_q;
    logic [3*CW-1:0]       e_c_q;
    logic [RW-1:0]         area2_q;
    logic [15:0]           min_tx_q, min_ty_q, steps_x_q, steps_y_q, cull_cnt_q;
    logic [VW-1:0]         base_q;
    logic [NUM_ATTR*DW-1:0] d0_q, d1_q;

    function automatic logic signed [AW-1:0] sext1(input logic signed [COORD_W-1:0] v);
        return $signed({v[COORD_W-1], v});
    endfunction

    function automatic logic signed [PW-1:0] sextm(input logic signed [COORD_W-1:0] v);
        return $signed({{COORD_W{v[COORD_W-1]}}, v});
    endfunction

    function automatic logic signed [31:0] s32(input logic signed [COORD_W-1:0] v);
        return $signed({{(32-COORD_W){v[COORD_W-1]}}, v});
    endfunction

    function automatic logic signed [31:0] clamp(input logic signed [31:0] v,
                                                 input logic signed [31:0] hi);
        if (v < 32'sd0) return 32'sd0;
        if (v > hi) return hi;
        return v;
    endfunction

    logic signed [AW-1:0] a_w [3];
    logic signed [AW-1:0] b_w [3];

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            a_w[k] = sext1(y_q[k]) - sext1(y_q[(k+1)%3]);
            b_w[k] = sext1(x_q[(k+1)%3]) - sext1(x_q[k]);
        end
    end

    // The CMUL state selects which edge k (and its successor j) feeds the multiplier pair.
    logic [1:0] ck, cj;
    logic signed [PW-1:0] m_xk, m_yj, m_xj, m_yk, prod0, prod1;
    logic signed [CW-1:0] c_w;

    always_comb begin
        ck = 2'd0;
        case (state_q)
            S_CMUL1: ck = 2'd1;
            S_CMUL2: ck = 2'd2;
            default: ck = 2'd0;
        endcase
        cj = (ck == 2'd2) ? 2'd0 : ck + 2'd1;
    end

    assign m_xk  = sextm(x_q[ck]);
    assign m_yj  = sextm(y_q[cj]);
    assign m_xj  = sextm(x_q[cj]);
    assign m_yk  = sextm(y_q[ck]);
    assign prod0 = m_xk * m_yj;
    assign prod1 = m_xj * m_yk;
    assign c_w   = $signed({prod0[PW-1], prod0}) - $signed({prod1[PW-1], prod1});

    logic signed [RW-1:0] area_w;
    assign area_w = $signed({{2{c_q[0][CW-1]}}, c_q[0]})
                  + $signed({{2{c_q[1][CW-1]}}, c_q[1]})
                  + $signed({{2{c_q[2][CW-1]}}, c_q[2]});

    logic signed [31:0] xs [3];
    logic signed [31:0] ys [3];
    logic signed [31:0] min_x, max_x, min_y, max_y;
    logic signed [31:0] cmin_x, cmax_x, cmin_y, cmax_y;
    logic [15:0] tmin_x, tmax_x, tmin_y, tmax_y;
    logic area_zero, area_neg, offscreen, cull;

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            xs[k] = s32(x_q[k]);
            ys[k] = s32(y_q[k]);
        end
        min_x = xs[0];
        max_x = xs[0];
        min_y = ys[0];
        max_y = ys[0];
        for (int k = 1; k < 3; k++) begin
            if (xs[k] < min_x) min_x = xs[k];
            if (xs[k] > max_x) max_x = xs[k];
            if (ys[k] < min_y) min_y = ys[k];
            if (ys[k] > max_y) max_y = ys[k];
        end
        cmin_x = clamp(min_x, XMAX);
        cmax_x = clamp(max_x, XMAX);
        cmin_y = clamp(min_y, YMAX);
        cmax_y = clamp(max_y, YMAX);
        tmin_x = 16'(cmin_x >>> TILE_LOG2);
        tmax_x = 16'(cmax_x >>> TILE_LOG2);
        tmin_y = 16'(cmin_y >>> TILE_LOG2);
        tmax_y = 16'(cmax_y >>> TILE_LOG2);
        // Off-screen test uses the unclamped box.
        area_zero = (area_w == '0);
        area_neg  = area_w[RW-1];
        offscreen = (max_x < 32'sd0) || (min_x > XMAX) || (max_y < 32'sd0) || (min_y > YMAX);
        cull = area_zero || ((mode_q == 2'd1) && area_neg)
             || ((mode_q == 2'd2) && !area_neg && !area_zero) || offscreen;
    end

    logic signed [ATTR_W-1:0] at0, at1, at2;
    logic signed [DW-1:0]     ad0_w, ad1_w;

    assign at0   = attr_q[0*VW + int'(attr_idx_q)*ATTR_W +: ATTR_W];
    assign at1   = attr_q[1*VW + int'(attr_idx_q)*ATTR_W +: ATTR_W];
    assign at2   = attr_q[2*VW + int'(attr_idx_q)*ATTR_W +: ATTR_W];
    assign ad0_w = $signed({at0[ATTR_W-1], at0}) - $signed({at2[ATTR_W-1], at2});
    assign ad1_w = $signed({at1[ATTR_W-1], at1}) - $signed({at2[ATTR_W-1], at2});

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (i_valid) state_d = S_EDGE;
            S_EDGE:  state_d = S_CMUL0;
            S_CMUL0: state_d = S_CMUL1;
            S_CMUL1: state_d = S_CMUL2;
            S_CMUL2: state_d = S_AREA;
            S_AREA:  state_d = cull ? S_IDLE : S_ATTR;
            S_ATTR:  if (attr_idx_q == 3'(NUM_ATTR-1)) state_d = S_OUT;
            S_OUT:   if (i_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            attr_idx_q <= '0;
            attr_q     <= '0;
            mode_q     <= '0;
            for (int k = 0; k < 3; k++) begin
                x_q[k] <= '0;
                y_q[k] <= '0;
                a_q[k] <= '0;
                b_q[k] <= '0;
                c_q[k] <= '0;
            end
            e_a_q      <= '0;
            e_b_q      <= '0;
            e_c_q      <= '0;
            area2_q    <= '0;
            min_tx_q   <= '0;
            min_ty_q   <= '0;
            steps_x_q  <= '0;
            steps_y_q  <= '0;
            base_q     <= '0;
            d0_q       <= '0;
            d1_q       <= '0;
            cull_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: if (i_valid) begin
                    for (int k = 0; k < 3; k++) begin
                        x_q[k] <= i_vtx_x[k*COORD_W +: COORD_W];
                        y_q[k] <= i_vtx_y[k*COORD_W +: COORD_W];
                    end
                    attr_q     <= i_attr;
                    mode_q     <= i_cull_mode;
                    attr_idx_q <= '0;
                end
                S_EDGE: for (int k = 0; k < 3; k++) begin
                    a_q[k] <= a_w[k];
                    b_q[k] <= b_w[k];
                end
                S_CMUL0, S_CMUL1, S_CMUL2: c_q[ck] <= c_w;
                S_AREA: begin
                    // Culled triangles leave the visible outputs untouched.
                    if (cull) begin
                        cull_cnt_q <= cull_cnt_q + 16'd1;
                    end else begin
                        for (int k = 0; k < 3; k++) begin
                            e_a_q[k*AW +: AW] <= a_q[k];
                            e_b_q[k*AW +: AW] <= b_q[k];
                            e_c_q[k*CW +: CW] <= c_q[k];
                        end
                        area2_q   <= area_w;
                        min_tx_q  <= tmin_x;
                        min_ty_q  <= tmin_y;
                        steps_x_q <= tmax_x - tmin_x + 16'd1;
                        steps_y_q <= tmax_y - tmin_y + 16'd1;
                    end
                end
                S_ATTR: begin
                    base_q[int'(attr_idx_q)*ATTR_W +: ATTR_W] <= at2;
                    d0_q[int'(attr_idx_q)*DW +: DW]           <= ad0_w;
                    d1_q[int'(attr_idx_q)*DW +: DW]           <= ad1_w;
                    attr_idx_q <= attr_idx_q + 3'd1;
                end
                default: ;
            endcase
        end
    end

    assign o_ready      = (state_q == S_IDLE);
    assign o_idle       = (state_q == S_IDLE);
    assign o_valid      = (state_q == S_OUT);
    assign o_e_a        = e_a_q;
    assign o_e_b        = e_b_q;
    assign o_e_c        = e_c_q;
    assign o_area2      = area2_q;
    assign o_min_tile_x = min_tx_q;
    assign o_min_tile_y = min_ty_q;
    assign o_steps_x    = steps_x_q;
    assign o_steps_y    = steps_y_q;
    assign o_attr_base  = base_q;
    assign o_attr_d0    = d0_q;
    assign o_attr_d1    = d1_q;
    assign o_cull_cnt   = cull_cnt_q;

endmodule

// File: tb/tb_ren_tri_setup_v2.sv
// Bench for ren_tri_setup_v2: vector table, hand-written corner sequences and random triangles
// checked through an expected-result queue against an integer reference model.
module tb_ren_tri_setup_v2;
    localparam int NA = 4;

    typedef struct packed {
        logic [1:0]                mode;
        logic [2:0][15:0]          x;
        logic [2:0][15:0]          y;
        logic [2:0][NA-1:0][15:0]  attr;
    } tri_t;

    typedef struct packed {
        logic                 cull;
        logic [2:0][16:0]     ea;
        logic [2:0][16:0]     eb;
        logic [2:0][32:0]     ec;
        logic [34:0]          area;
        logic [15:0]          mtx, mty, sx, sy;
        logic [NA-1:0][15:0]  base;
        logic [NA-1:0][16:0]  d0;
        logic [NA-1:0][16:0]  d1;
    } exp_t;

    typedef struct packed {
        tri_t        t;
        logic        cull;
        logic [34:0] area;
        logic [15:0] mtx, mty, sx, sy;
        logic [15:0] base0;
        logic [16:0] d00, d10;
    } vec_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic i_valid = 1'b0;
    logic i_ready = 1'b1;
    logic [1:0] i_cull_mode = '0;
    logic [47:0] i_vtx_x = '0;
    logic [47:0] i_vtx_y = '0;
    logic [3*NA*16-1:0] i_attr = '0;
    logic o_ready, o_valid, o_idle;
    logic [50:0] o_e_a, o_e_b;
    logic [98:0] o_e_c;
    logic [34:0] o_area2;
    logic [15:0] o_min_tile_x, o_min_tile_y, o_steps_x, o_steps_y, o_cull_cnt;
    logic [NA*16-1:0] o_attr_base;
    logic [NA*17-1:0] o_attr_d0, o_attr_d1;

    ren_tri_setup_v2 #(.NUM_ATTR(NA)) dut (
        .clk(clk), .rstn(rstn), .i_valid(i_valid), .o_ready(o_ready),
        .i_vtx_x(i_vtx_x), .i_vtx_y(i_vtx_y), .i_attr(i_attr), .i_cull_mode(i_cull_mode),
        .o_valid(o_valid), .i_ready(i_ready), .o_e_a(o_e_a), .o_e_b(o_e_b), .o_e_c(o_e_c),
        .o_area2(o_area2), .o_min_tile_x(o_min_tile_x), .o_min_tile_y(o_min_tile_y),
        .o_steps_x(o_steps_x), .o_steps_y(o_steps_y), .o_attr_base(o_attr_base),
        .o_attr_d0(o_attr_d0), .o_attr_d1(o_attr_d1), .o_cull_cnt(o_cull_cnt), .o_idle(o_idle)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;
    exp_t exp_q[$];
    exp_t last_exp = '0;
    vec_t vecs[10];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic exp_t model(input tri_t t);
        exp_t e;
        longint x[3], y[3];
        longint a, b, c, area, mnx, mxx, mny, mxy, clx, chx, cly, chy, v0, v1, v2;
        e = '0;
        area = 0;
        for (int k = 0; k < 3; k++) begin
            x[k] = longint'($signed(t.x[k]));
            y[k] = longint'($signed(t.y[k]));
        end
        for (int k = 0; k < 3; k++) begin
            a = y[k] - y[(k+1)%3];
            b = x[(k+1)%3] - x[k];
            c = x[k] * y[(k+1)%3] - x[(k+1)%3] * y[k];
            e.ea[k] = 17'(a);
            e.eb[k] = 17'(b);
            e.ec[k] = 33'(c);
            area += c;
        end
        e.area = 35'(area);
        mnx = x[0]; mxx = x[0]; mny = y[0]; mxy = y[0];
        for (int k = 1; k < 3; k++) begin
            if (x[k] < mnx) mnx = x[k];
            if (x[k] > mxx) mxx = x[k];
            if (y[k] < mny) mny = y[k];
            if (y[k] > mxy) mxy = y[k];
        end
        e.cull = (area == 0) || (t.mode == 2'd1 && area < 0) || (t.mode == 2'd2 && area > 0)
               || (mxx < 0) || (mnx > 639) || (mxy < 0) || (mny > 479);
        clx = (mnx < 0) ? 0 : ((mnx > 639) ? 639 : mnx);
        chx = (mxx < 0) ? 0 : ((mxx > 639) ? 639 : mxx);
        cly = (mny < 0) ? 0 : ((mny > 479) ? 479 : mny);
        chy = (mxy < 0) ? 0 : ((mxy > 479) ? 479 : mxy);
        e.mtx = 16'(clx / 8);
        e.mty = 16'(cly / 8);
        e.sx  = 16'(chx / 8 - clx / 8 + 1);
        e.sy  = 16'(chy / 8 - cly / 8 + 1);
        for (int i = 0; i < NA; i++) begin
            v0 = longint'($signed(t.attr[0][i]));
            v1 = longint'($signed(t.attr[1][i]));
            v2 = longint'($signed(t.attr[2][i]));
            e.base[i] = t.attr[2][i];
            e.d0[i] = 17'(v0 - v2);
            e.d1[i] = 17'(v1 - v2);
        end
        return e;
    endfunction

    function automatic tri_t mk(input int mode, input int x0, input int y0, input int x1,
                                input int y1, input int x2, input int y2,
                                input int a0, input int a1, input int a2);
        tri_t t;
        t.mode = 2'(mode);
        t.x[0] = 16'(x0); t.y[0] = 16'(y0);
        t.x[1] = 16'(x1); t.y[1] = 16'(y1);
        t.x[2] = 16'(x2); t.y[2] = 16'(y2);
        for (int v = 0; v < 3; v++)
            for (int i = 1; i < NA; i++) t.attr[v][i] = 16'($urandom);
        t.attr[0][0] = 16'(a0);
        t.attr[1][0] = 16'(a1);
        t.attr[2][0] = 16'(a2);
        return t;
    endfunction

    function automatic vec_t mkv(input tri_t t, input int cull, input int area, input int mtx,
                                 input int mty, input int sx, input int sy, input int base0,
                                 input int d00, input int d10);
        vec_t v;
        v.t = t;
        v.cull = (cull != 0);
        v.area = 35'(area);
        v.mtx = 16'(mtx); v.mty = 16'(mty);
        v.sx = 16'(sx); v.sy = 16'(sy);
        v.base0 = 16'(base0);
        v.d00 = 17'(d00);
        v.d10 = 17'(d10);
        return v;
    endfunction

    task automatic cmp_out(input string tag, input exp_t e);
        chk({tag, ".e_a"}, 128'(o_e_a), 128'(e.ea));
        chk({tag, ".e_b"}, 128'(o_e_b), 128'(e.eb));
        chk({tag, ".e_c"}, 128'(o_e_c), 128'(e.ec));
        chk({tag, ".area2"}, 128'(o_area2), 128'(e.area));
        chk({tag, ".min_tx"}, 128'(o_min_tile_x), 128'(e.mtx));
        chk({tag, ".min_ty"}, 128'(o_min_tile_y), 128'(e.mty));
        chk({tag, ".steps_x"}, 128'(o_steps_x), 128'(e.sx));
        chk({tag, ".steps_y"}, 128'(o_steps_y), 128'(e.sy));
        chk({tag, ".base"}, 128'(o_attr_base), 128'(e.base));
        chk({tag, ".d0"}, 128'(o_attr_d0), 128'(e.d0));
        chk({tag, ".d1"}, 128'(o_attr_d1), 128'(e.d1));
    endtask

    task automatic send(input string tag, input tri_t t, input exp_t e, input int hold);
        int n;
        exp_t cur;
        exp_q.push_back(e);
        n = 0;
        while (!o_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, ".ready"}, 128'(o_ready), 128'(1));
        i_vtx_x = t.x; i_vtx_y = t.y; i_attr = t.attr; i_cull_mode = t.mode;
        i_ready = (hold == 0);
        i_valid = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        i_vtx_x = ~t.x; i_vtx_y = ~t.y; i_attr = ~t.attr; i_cull_mode = ~t.mode;
        n = 0;
        while (!o_valid && !o_idle && n < 40) begin
            @(negedge clk);
            n++;
        end
        cur = exp_q.pop_front();
        if (cur.cull) begin
            exp_cnt++;
            chk({tag, ".cull_lat"}, 128'(n), 128'(5));
            chk({tag, ".cull_valid"}, 128'(o_valid), 128'(0));
            chk({tag, ".cull_cnt"}, 128'(o_cull_cnt), 128'(16'(exp_cnt)));
            cmp_out({tag, ".kept"}, last_exp);
        end else begin
            chk({tag, ".out_lat"}, 128'(n), 128'(9));
            chk({tag, ".valid"}, 128'(o_valid), 128'(1));
            chk({tag, ".cnt"}, 128'(o_cull_cnt), 128'(16'(exp_cnt)));
            cmp_out(tag, cur);
            for (int h = 0; h < hold; h++) begin
                if (h == 2) begin
                    i_vtx_x = t.y;
                    i_valid = 1'b1;
                end
                @(negedge clk);
                i_valid = 1'b0;
                chk({tag, ".hold_valid"}, 128'(o_valid), 128'(1));
                chk({tag, ".hold_ready"}, 128'(o_ready), 128'(0));
                cmp_out({tag, ".hold"}, cur);
            end
            i_ready = 1'b1;
            @(negedge clk);
            chk({tag, ".done_valid"}, 128'(o_valid), 128'(0));
            chk({tag, ".done_ready"}, 128'(o_ready), 128'(1));
            last_exp = cur;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        tri_t  t;
        exp_t  e;
        logic  saw;

        rstn = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset.ready", 128'(o_ready), 128'(1));
        chk("reset.idle", 128'(o_idle), 128'(1));
        chk("reset.valid", 128'(o_valid), 128'(0));
        chk("reset.cnt", 128'(o_cull_cnt), 128'(0));
        chk("reset.area2", 128'(o_area2), 128'(0));
        rstn = 1'b1;
        @(negedge clk);

        // Basic triangle with fully hand-derived edge coefficients.
        t = mk(0, 10, 10, 50, 10, 10, 40, 100, 60, 20);
        e = model(t);
        e.ea[0] = 17'd0;       e.eb[0] = 17'd40;      e.ec[0] = -33'sd400;
        e.ea[1] = -17'sd30;    e.eb[1] = -17'sd40;    e.ec[1] = 33'sd1900;
        e.ea[2] = 17'd30;      e.eb[2] = 17'd0;       e.ec[2] = -33'sd300;
        e.area = 35'd1200;
        e.mtx = 16'd1; e.mty = 16'd1; e.sx = 16'd6; e.sy = 16'd5;
        e.base[0] = 16'd20; e.d0[0] = 17'd80; e.d1[0] = 17'd40;
        e.cull = 1'b0;
        send("basic", t, e, 0);

        vecs[0] = mkv(mk(0, 10, 10, 50, 10, 10, 40, 100, 60, 20), 0, 1200, 1, 1, 6, 5, 20, 80, 40);
        vecs[1] = mkv(mk(1, 10, 10, 10, 40, 50, 10, 100, 20, 60), 1, -1200, 0, 0, 0, 0, 0, 0, 0);
        vecs[2] = mkv(mk(2, 10, 10, 10, 40, 50, 10, 100, 20, 60), 0, -1200, 1, 1, 6, 5, 60, 40, -40);
        vecs[3] = mkv(mk(2, 10, 10, 50, 10, 10, 40, 100, 60, 20), 1, 1200, 0, 0, 0, 0, 0, 0, 0);
        vecs[4] = mkv(mk(3, 10, 10, 10, 40, 50, 10, 100, 20, 60), 0, -1200, 1, 1, 6, 5, 60, 40, -40);
        vecs[5] = mkv(mk(0, 0, 0, 10, 10, 20, 20, 1, 2, 3), 1, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[6] = mkv(mk(0, 700, 10, 750, 10, 700, 60, 1, 2, 3), 1, 2500, 0, 0, 0, 0, 0, 0, 0);
        vecs[7] = mkv(mk(0, 10, -50, 50, -40, 30, -10, 1, 2, 3), 1, 1400, 0, 0, 0, 0, 0, 0, 0);
        vecs[8] = mkv(mk(0, -20, -5, 700, 10, 100, 500, 5, -3, 7), 0, 361800, 0, 0, 80, 60, 7, -2, -10);
        vecs[9] = mkv(mk(1, 10, 10, 50, 10, 10, 40, 100, 60, 20), 0, 1200, 1, 1, 6, 5, 20, 80, 40);

        for (int i = 0; i < 10; i++) begin
            e = model(vecs[i].t);
            e.cull = vecs[i].cull;
            if (!vecs[i].cull) begin
                e.area = vecs[i].area;
                e.mtx = vecs[i].mtx; e.mty = vecs[i].mty;
                e.sx = vecs[i].sx;   e.sy = vecs[i].sy;
                e.base[0] = vecs[i].base0;
                e.d0[0] = vecs[i].d00;
                e.d1[0] = vecs[i].d10;
            end
            send($sformatf("vec%0d", i), vecs[i].t, e, 0);
        end

        // Backpressure for five cycles, then a back-to-back triangle.
        send("bp", vecs[2].t, model(vecs[2].t), 5);
        send("bp_next", vecs[8].t, model(vecs[8].t), 0);

        // Reset while the multiplier is busy on edge 1.
        t = vecs[0].t;
        i_vtx_x = t.x; i_vtx_y = t.y; i_attr = t.attr; i_cull_mode = t.mode;
        i_ready = 1'b1;
        i_valid = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst.busy", 128'(o_idle), 128'(0));
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        chk("rst.idle", 128'(o_idle), 128'(1));
        chk("rst.ready", 128'(o_ready), 128'(1));
        chk("rst.valid", 128'(o_valid), 128'(0));
        chk("rst.cnt", 128'(o_cull_cnt), 128'(0));
        chk("rst.e_a", 128'(o_e_a), 128'(0));
        chk("rst.area2", 128'(o_area2), 128'(0));
        chk("rst.steps_x", 128'(o_steps_x), 128'(0));
        chk("rst.base", 128'(o_attr_base), 128'(0));
        exp_cnt = 0;
        last_exp = '0;
        saw = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (o_valid) saw = 1'b1;
        end
        chk("rst.no_valid", 128'(saw), 128'(0));
        send("after_rst", vecs[0].t, model(vecs[0].t), 0);

        for (int r = 0; r < 24; r++) begin
            t.mode = 2'($urandom_range(0, 3));
            for (int v = 0; v < 3; v++) begin
                if (r < 12) begin
                    t.x[v] = 16'(int'($urandom_range(0, 900)) - 100);
                    t.y[v] = 16'(int'($urandom_range(0, 700)) - 100);
                end else begin
                    t.x[v] = 16'($urandom);
                    t.y[v] = 16'($urandom);
                end
                for (int i = 0; i < NA; i++) t.attr[v][i] = 16'($urandom);
            end
            send($sformatf("rnd%0d", r), t, model(t), ($urandom_range(0, 3) == 0) ? 3 : 0);
        end

        chk("queue_empty", 128'(exp_q.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ren_tri_setup_v2.md
Name: ren_tri_setup_v2

Overview:
- Parametrised successor to the triangle setup stage. Accepts one screen-space triangle with NUM_ATTR per-vertex attributes and produces the outputs the binner queue consumes: edge coefficients, a clamped tile bounding box and per-attribute deltas.
- Adds things the current setup stage does not have: signed-area computation, degenerate/back-face/off-screen culling with a cull counter, and a valid/ready handshake on both sides.
- Uses signed integer arithmetic with one shared multiplier pair; the FP SIMD is not used.

Parameters:
- COORD_W, 16, signed vertex coordinate width in integer pixels.
- ATTR_W, 16, signed attribute width.
- NUM_ATTR, 4, attributes per vertex; legal range 1..8.
- TILE_LOG2, 3, log2 of the tile size in pixels.
- SCREEN_W, 640, screen width in pixels.
- SCREEN_H, 480, screen height in pixels.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rstn  in  1  synchronous active-low reset.
- i_valid  in  1  input triangle valid.
- o_ready  out  1  setup can accept a triangle; equals state==IDLE.
- i_vtx_x  in  3*COORD_W  packed x coordinates {v2,v1,v0}.
- i_vtx_y  in  3*COORD_W  packed y coordinates {v2,v1,v0}.
- i_attr  in  3*NUM_ATTR*ATTR_W  packed {v2,v1,v0}; each vertex packs attr[NUM_ATTR-1..0].
- i_cull_mode  in  2  0=none, 1=cull CW, 2=cull CCW, 3=none.
- o_valid  out  1  result valid.
- i_ready  in  1  downstream accepts the result.
- o_e_a  out  3*(COORD_W+1)  packed {e2,e1,e0} edge a coefficients.
- o_e_b  out  3*(COORD_W+1)  packed {e2,e1,e0} edge b coefficients.
- o_e_c  out  3*(2*COORD_W+1)  packed {e2,e1,e0} edge c coefficients.
- o_area2  out  2*COORD_W+3  twice the signed area.
- o_min_tile_x  out  16  minimum tile x index.
- o_min_tile_y  out  16  minimum tile y index.
- o_steps_x  out  16  number of tiles spanned in x.
- o_steps_y  out  16  number of tiles spanned in y.
- o_attr_base  out  NUM_ATTR*ATTR_W  attributes of v2.
- o_attr_d0  out  NUM_ATTR*(ATTR_W+1)  attr(v0)-attr(v2), per attribute.
- o_attr_d1  out  NUM_ATTR*(ATTR_W+1)  attr(v1)-attr(v2), per attribute.
- o_cull_cnt  out  16  culled-triangle count; wraps at 16 bits.
- o_idle  out  1  state==IDLE.

Behaviour:
- Reset: when rstn is low at a clock edge, state goes to IDLE, all registered outputs and o_cull_cnt clear to 0, and any in-flight triangle is discarded. After reset o_ready=1, o_idle=1, o_valid=0.
- Input handshake: a triangle is accepted at edge E0 when i_valid and o_ready are both high. All inputs, including i_cull_mode, are captured at E0. i_valid while not IDLE is ignored.
- Edge k runs from vertex k to vertex j=(k+1)%3:
  - a = yk - yj
  - b = xj - xk
  - c = xk*yj - xj*yk
  - All values are sign-extended and exact, with no truncation.
- FSM sequence: IDLE → EDGE → CMUL0 → CMUL1 → CMUL2 → AREA → ATTR0..ATTR(NUM_ATTR-1) → OUT → IDLE.
  - EDGE registers all a and b values at E1.
  - CMULk registers ck using the shared multiplier pair; edges E2, E3, E4.
  - AREA at E5: area2 = c0+c1+c2; computes the bounding box and the cull decision.
  - ATTRi registers d0[i], d1[i] and base[i], one attribute per cycle.
  - OUT holds until i_ready.
- Cull conditions, evaluated in AREA. A triangle is culled if any of these holds:
  - area2 == 0;
  - i_cull_mode==1 and area2<0 (CW);
  - i_cull_mode==2 and area2>0 (CCW);
  - bbox max_x<0, min_x>SCREEN_W-1, max_y<0, or min_y>SCREEN_H-1.
- Culled triangle: state goes AREA→IDLE at E5 and o_cull_cnt increments by 1. o_valid never rises, o_ready is high after E5, and the other outputs keep their previous values.
- Bounding box:
  - Take min/max of the vertex x and y values.
  - Clamp x to [0, SCREEN_W-1] and y to [0, SCREEN_H-1].
  - min_tile = clamped_min >> TILE_LOG2; max_tile = clamped_max >> TILE_LOG2.
  - steps = max_tile - min_tile + 1.
- Latency: o_valid rises after edge E0+5+NUM_ATTR, i.e. 9 cycles for NUM_ATTR=4.
- Output handshake:
  - All outputs stay stable while o_valid=1 and i_ready=0.
  - The transfer completes at the first edge with o_valid and i_ready both high; state goes to IDLE and o_valid drops.
  - A new triangle can be accepted on the following edge.
- Throughput: 1 triangle per (7+NUM_ATTR) cycles with i_ready held high.

Test Plan:
- Basic triangle, v0=(10,10), v1=(50,10), v2=(10,40), mode 0, attr0 of v0/v1/v2 = 100/60/20:
  - edges (a,b,c): e0=(0,40,-400), e1=(-30,-40,1900), e2=(30,0,-300); area2=1200;
  - min tile (1,1), steps (6,5); d0=80, d1=40, base=20;
  - o_valid rises 9 cycles after accept.
- Same triangle with v1 and v2 swapped, mode 1 → area2=-1200, culled, o_cull_cnt=1, o_valid stays 0, o_ready high 5 cycles after accept. Same stimulus with mode 2 → not culled.
- Degenerate and off-screen cases, each culled with o_cull_cnt incrementing:
  - collinear (0,0),(10,10),(20,20) → area2=0;
  - vertices (700,10),(750,10),(700,60) → off-screen.
- Clamping: (-20,-5),(700,10),(100,500) → min tile (0,0), steps (80,60).
- Backpressure: hold i_ready=0 for 5 cycles while o_valid=1 → outputs unchanged, o_ready=0, pulsed i_valid ignored. Release → handshake completes in one cycle, then the next triangle is accepted.
- Reset: assert rstn=0 during CMUL1 → next cycle IDLE, outputs 0, o_cull_cnt=0, no o_valid. The next triangle then completes normally.
